// File: rtl/harvard_fetch_pkg.sv
// Shared types and default constants for the Harvard CPU instruction-fetch front end.
// Optional statistics counters are enabled by defining FETCH_STATS_EN.
package harvard_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  localparam int          DEF_DATA_W   = 32;
  localparam int          DEF_ADDR_W   = 32;
  localparam int          DEF_DEPTH    = 4;
  localparam logic [31:0] DEF_RESET_PC = 32'd0;
  localparam int          DEF_PC_STEP  = 1;

  // Saturating 32-bit accumulate used by the statistics counters.
  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? '1 : sum[31:0];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous first-word-visible FIFO holding {instruction, pc} pairs for the fetch unit.
// Flush empties it in one cycle; push when full and pop when empty are ignored.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (count != DEPTH_C);
  assign do_pop  = pop && (count != '0);
  assign valid   = (count != '0);
  assign rdata   = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; entries are only observable once
  // count says they were written, so clearing them would buy nothing.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/harvard_fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, runs the imem req/ack handshake and
// buffers words in a prefetch queue. Define FETCH_STATS_EN to add fetch/discard counters.
module harvard_fetch_unit
  import harvard_fetch_pkg::*;
#(
  parameter int                DATA_W   = DEF_DATA_W,
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                DEPTH    = DEF_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC),
  parameter int                PC_STEP  = DEF_PC_STEP
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetch_en,
  output logic                     imem_req,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic                     imem_ack,
  input  logic [DATA_W-1:0]        imem_rdata,
  output logic                     ir_valid,
  output logic [DATA_W-1:0]        ir_data,
  output logic [ADDR_W-1:0]        ir_pc,
  input  logic                     ir_ready,
  input  logic                     redirect,
  input  logic [ADDR_W-1:0]        redirect_pc,
`ifdef FETCH_STATS_EN
  output logic [31:0]              stat_fetched,
  output logic [31:0]              stat_discarded,
`endif
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]     DEPTH_C = CW'(DEPTH);
  localparam logic [ADDR_W-1:0] STEP_C  = ADDR_W'(PC_STEP);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] addr_d;
  logic              push;
  logic              pop;
  logic [CW-1:0]     q_after;

  // Redirect outranks everything: it blocks the push and the pop of the same cycle.
  assign push     = (state_q == WAIT) && imem_ack && !redirect;
  assign pop      = ir_valid && ir_ready && !redirect;
  assign q_after  = q_count + CW'(push) - CW'(pop);
  assign imem_req = (state_q != IDLE);

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = imem_addr;
    if (redirect) fetch_pc_d = redirect_pc;
    unique case (state_q)
      IDLE: begin
        if (fetch_en && !redirect && (q_count < DEPTH_C)) begin
          state_d = WAIT;
          addr_d  = fetch_pc_q;
        end
      end
      WAIT: begin
        if (redirect) begin
          state_d = imem_ack ? IDLE : DRAIN;
        end else if (imem_ack) begin
          fetch_pc_d = imem_addr + STEP_C;
          // Chain the next request only if the queue can still absorb it.
          if (fetch_en && (q_after < DEPTH_C)) addr_d = imem_addr + STEP_C;
          else                                 state_d = IDLE;
        end
      end
      DRAIN: begin
        if (imem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      imem_addr  <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      imem_addr  <= addr_d;
    end
  end

  fetch_fifo #(
    .WIDTH (DATA_W + ADDR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata ({imem_rdata, imem_addr}),
    .rdata ({ir_data, ir_pc}),
    .valid (ir_valid),
    .count (q_count)
  );

`ifdef FETCH_STATS_EN
  logic drop_ack;
  assign drop_ack = imem_ack &&
                    ((state_q == DRAIN) || ((state_q == WAIT) && redirect));

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_fetched   <= '0;
      stat_discarded <= '0;
    end else begin
      stat_fetched   <= sat_add32(stat_fetched, {31'd0, push});
      stat_discarded <= sat_add32(stat_discarded,
                                  {31'd0, drop_ack} + (redirect ? 32'(q_count) : 32'd0));
    end
  end
`endif

endmodule

// File: tb/tb_harvard_fetch_unit.sv
// Directed self-checking bench for harvard_fetch_unit (default parameters).
// Memory returns addr ^ 0xC0DE0000; ack latency is programmable or forced by hand.
module tb_harvard_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        ir_valid;
  logic [31:0] ir_data;
  logic [31:0] ir_pc;
  logic        ir_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [2:0]  q_count;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched;
  logic [31:0] stat_discarded;
`endif

  int   errors = 0;
  int   checks = 0;
  logic ack_auto;
  logic ack_force;
  int   ack_lat;
  int   wait_cnt;

  always #5 clk = ~clk;

  harvard_fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_en    (fetch_en),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .ir_valid    (ir_valid),
    .ir_data     (ir_data),
    .ir_pc       (ir_pc),
    .ir_ready    (ir_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
`ifdef FETCH_STATS_EN
    .stat_fetched   (stat_fetched),
    .stat_discarded (stat_discarded),
`endif
    .q_count     (q_count)
  );

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  assign imem_rdata = word_of(imem_addr);
  assign imem_ack   = ack_auto ? (imem_req && (wait_cnt >= ack_lat)) : ack_force;

  always @(posedge clk) begin
    if (rst || !imem_req || imem_ack) wait_cnt <= 0;
    else                              wait_cnt <= wait_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; fetch_en = 1'b0; ir_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    ack_auto = 1'b1; ack_lat = 0; ack_force = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1; fetch_en = 1'b1;
    step();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %0b want 0", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
    checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", ir_valid); end
    checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", q_count); end
    rst = 1'b0; fetch_en = 1'b0;
  endtask

  task automatic test_zero_wait();
    do_reset();
    fetch_en = 1'b1; ir_ready = 1'b1;
    step();
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL zw_req_c1: got %0b want 1", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL zw_addr_c1: got %h want 0", imem_addr); end
    checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL zw_valid_c1: got %0b want 0", ir_valid); end
    step();
    for (int i = 0; i < 6; i++) begin
      checks++; if (ir_valid !== 1'b1) begin errors++; $display("FAIL zw_valid[%0d]: got %0b want 1", i, ir_valid); end
      checks++; if (ir_pc !== 32'(i)) begin errors++; $display("FAIL zw_pc[%0d]: got %h want %h", i, ir_pc, 32'(i)); end
      checks++; if (ir_data !== word_of(32'(i))) begin errors++; $display("FAIL zw_data[%0d]: got %h want %h", i, ir_data, word_of(32'(i))); end
      checks++; if (q_count > 3'd1) begin errors++; $display("FAIL zw_count[%0d]: got %0d want <=1", i, q_count); end
      step();
    end
    fetch_en = 1'b0;
  endtask

  task automatic test_wait_states();
    int          pushes;
    logic        prev_req;
    logic        prev_ack;
    logic [31:0] prev_addr;
    do_reset();
    ack_lat = 3; fetch_en = 1'b1; ir_ready = 1'b0;
    pushes = 0; prev_req = 1'b0; prev_ack = 1'b0; prev_addr = '0;
    for (int c = 0; c < 40; c++) begin
      if (prev_req && !prev_ack) begin
        checks++;
        if (!imem_req || imem_addr !== prev_addr) begin
          errors++; $display("FAIL ws_hold[%0d]: req=%0b addr=%h want req=1 addr=%h", c, imem_req, imem_addr, prev_addr);
        end
      end
      if (imem_req && imem_ack) pushes++;
      prev_req = imem_req; prev_ack = imem_ack; prev_addr = imem_addr;
      step();
    end
    checks++; if (pushes != 4) begin errors++; $display("FAIL ws_pushes: got %0d want 4", pushes); end
    checks++; if (q_count !== 3'd4) begin errors++; $display("FAIL ws_count: got %0d want 4", q_count); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL ws_req_full: got %0b want 0", imem_req); end
    fetch_en = 1'b0; ir_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (ir_valid !== 1'b1 || ir_pc !== 32'(i)) begin errors++; $display("FAIL ws_pop[%0d]: valid=%0b pc=%h want 1 %h", i, ir_valid, ir_pc, 32'(i)); end
      step();
    end
    checks++; if (ir_valid !== 1'b0 || q_count !== 3'd0) begin errors++; $display("FAIL ws_empty: valid=%0b count=%0d want 0 0", ir_valid, q_count); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL ws_req_off: got %0b want 0", imem_req); end
    ir_ready = 1'b0;
  endtask

  task automatic test_redirect_drain();
    do_reset();
    ack_lat = 2; fetch_en = 1'b1; ir_ready = 1'b1;
    step();
    checks++; if (imem_req !== 1'b1 || imem_ack !== 1'b0) begin errors++; $display("FAIL rd_setup: req=%0b ack=%0b want 1 0", imem_req, imem_ack); end
    redirect = 1'b1; redirect_pc = 32'h100;
    step();
    redirect = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL rd_drain_hold: req=%0b addr=%h want 1 0", imem_req, imem_addr); end
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL rd_drain_hold2: req=%0b addr=%h want 1 0", imem_req, imem_addr); end
    step();
    checks++; if (ir_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL rd_dropped: valid=%0b req=%0b want 0 0", ir_valid, imem_req); end
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL rd_new_addr: req=%0b addr=%h want 1 100", imem_req, imem_addr); end
    for (int k = 0; k < 10 && !ir_valid; k++) step();
    checks++;
    if (ir_valid !== 1'b1 || ir_pc !== 32'h100 || ir_data !== word_of(32'h100)) begin
      errors++; $display("FAIL rd_first_pc: valid=%0b pc=%h data=%h want 1 100 %h", ir_valid, ir_pc, ir_data, word_of(32'h100));
    end
    fetch_en = 1'b0; ir_ready = 1'b0;
  endtask

  task automatic test_redirect_ack();
    do_reset();
    ack_auto = 1'b0; ack_force = 1'b1; fetch_en = 1'b1; ir_ready = 1'b0;
    step(); step(); step();
    checks++; if (q_count !== 3'd2 || imem_req !== 1'b1) begin errors++; $display("FAIL ra_setup: count=%0d req=%0b want 2 1", q_count, imem_req); end
    redirect = 1'b1; redirect_pc = 32'h200;
    step();
    redirect = 1'b0; ack_force = 1'b0;
    checks++; if (q_count !== 3'd0 || ir_valid !== 1'b0) begin errors++; $display("FAIL ra_flush: count=%0d valid=%0b want 0 0", q_count, ir_valid); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL ra_idle: got %0b want 0", imem_req); end
`ifdef FETCH_STATS_EN
    checks++; if (stat_fetched !== 32'd2 || stat_discarded !== 32'd3) begin errors++; $display("FAIL ra_stats: fetched=%0d discarded=%0d want 2 3", stat_fetched, stat_discarded); end
`endif
    ack_auto = 1'b1; ack_lat = 0;
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin errors++; $display("FAIL ra_new_addr: req=%0b addr=%h want 1 200", imem_req, imem_addr); end
    step();
    checks++; if (ir_valid !== 1'b1 || ir_pc !== 32'h200) begin errors++; $display("FAIL ra_first_pc: valid=%0b pc=%h want 1 200", ir_valid, ir_pc); end
    fetch_en = 1'b0;
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'hFFFF_FFFE; exp_pc[1] = 32'hFFFF_FFFF; exp_pc[2] = 32'h0;
    do_reset();
    ir_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    step();
    redirect = 1'b0; fetch_en = 1'b1;
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFE) begin errors++; $display("FAIL wrap_addr: req=%0b addr=%h want 1 fffffffe", imem_req, imem_addr); end
    step();
    for (int i = 0; i < 3; i++) begin
      checks++; if (ir_valid !== 1'b1 || ir_pc !== exp_pc[i]) begin errors++; $display("FAIL wrap_pc[%0d]: valid=%0b pc=%h want 1 %h", i, ir_valid, ir_pc, exp_pc[i]); end
      step();
    end
    fetch_en = 1'b0; ir_ready = 1'b0;
  endtask

  task automatic test_reset_in_drain();
    do_reset();
    ack_auto = 1'b0; ack_force = 1'b0; fetch_en = 1'b1; ir_ready = 1'b0;
    step();
    redirect = 1'b1; redirect_pc = 32'h300;
    step();
    redirect = 1'b0;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rst_drain_setup: req=%0b want 1", imem_req); end
    rst = 1'b1; fetch_en = 1'b0;
    step();
    checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin errors++; $display("FAIL rst_drain_port: req=%0b addr=%h want 0 0", imem_req, imem_addr); end
    checks++; if (ir_valid !== 1'b0 || q_count !== 3'd0) begin errors++; $display("FAIL rst_drain_queue: valid=%0b count=%0d want 0 0", ir_valid, q_count); end
`ifdef FETCH_STATS_EN
    checks++; if (stat_fetched !== 32'd0 || stat_discarded !== 32'd0) begin errors++; $display("FAIL rst_drain_stats: fetched=%0d discarded=%0d want 0 0", stat_fetched, stat_discarded); end
`endif
    rst = 1'b0; ack_force = 1'b1;
    step();
    checks++; if (imem_req !== 1'b0 || ir_valid !== 1'b0) begin errors++; $display("FAIL rst_late_ack: req=%0b valid=%0b want 0 0", imem_req, ir_valid); end
    ack_force = 1'b0; ack_auto = 1'b1; ack_lat = 0; fetch_en = 1'b1;
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL rst_restart_addr: req=%0b addr=%h want 1 0", imem_req, imem_addr); end
    step();
    checks++; if (ir_valid !== 1'b1 || ir_pc !== 32'h0) begin errors++; $display("FAIL rst_restart_pc: valid=%0b pc=%h want 1 0", ir_valid, ir_pc); end
    fetch_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_redirect_drain();
    test_redirect_ack();
    test_wrap();
    test_reset_in_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
